// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage next-PC generator with a direct-mapped BTB.
//
// Drives the fetch pc (also the gshare index PC), takes the gshare direction
// for that pc in the same cycle, and selects the next pc from redirect, stall,
// BTB prediction or sequential pc + 4. Resolved taken control flow fills the
// BTB. Resolved not-taken conditional branches evict their own entry.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   stall             hold pc (redirect still wins)
//   predicted_flag    gshare direction for the current pc
//   redirect          mispredict from resolve, next pc = redirect_pc
//   redirect_pc       corrected next pc
//   is_control        resolve op is a branch or jump
//   is_br             resolve op is a conditional branch
//   is_taken          resolved direction
//   branch_pc         pc of the resolving op
//   branch_target     resolved target of the resolving op
//   pc                current fetch pc
//   pc_valid          pc is a real fetch (low during the boot cycle)
//   pred_taken        BTB/gshare predict a redirect for pc
//   pred_target       predicted next pc for pc
module fetch_pc_gen #(
    parameter int unsigned                     OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned                     BTB_BITS_NUM         = 6,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] RESET_VECTOR         = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            predicted_flag,
    input  logic                            redirect,
    input  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc,
    input  logic                            is_control,
    input  logic                            is_br,
    input  logic                            is_taken,
    input  logic [OPTION_OPERAND_WIDTH-1:0] branch_pc,
    input  logic [OPTION_OPERAND_WIDTH-1:0] branch_target,
    output logic [OPTION_OPERAND_WIDTH-1:0] pc,
    output logic                            pc_valid,
    output logic                            pred_taken,
    output logic [OPTION_OPERAND_WIDTH-1:0] pred_target
);

    localparam int unsigned W       = OPTION_OPERAND_WIDTH;
    localparam int unsigned TagW    = W - BTB_BITS_NUM - 2;
    localparam int unsigned Entries = 1 << BTB_BITS_NUM;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e               state_q, state_d;
    logic [W-1:0]         pc_q, pc_d;
    logic [Entries-1:0]   btb_valid_q, btb_valid_d;

    // Payload arrays carry no reset; the valid bits alone gate their use.
    logic [TagW-1:0]      btb_tag_q    [Entries];
    logic [W-1:0]         btb_target_q [Entries];
    logic                 btb_cond_q   [Entries];

    logic [BTB_BITS_NUM-1:0] rd_idx, wr_idx;
    logic [TagW-1:0]         rd_tag, wr_tag;
    logic                    hit;
    logic                    wr_en, inv_en;
    logic [1:0]              unused_branch_pc_lsb;

    // Instructions are word aligned; byte offset bits play no part in the BTB.
    assign unused_branch_pc_lsb = branch_pc[1:0];

    assign rd_idx = pc_q[BTB_BITS_NUM+1:2];
    assign rd_tag = pc_q[W-1:BTB_BITS_NUM+2];
    assign wr_idx = branch_pc[BTB_BITS_NUM+1:2];
    assign wr_tag = branch_pc[W-1:BTB_BITS_NUM+2];

    // Lookup reads the pre-write contents; no same-cycle bypass.
    always_comb begin
        hit         = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
        pred_taken  = hit && (!btb_cond_q[rd_idx] || predicted_flag);
        pred_target = pred_taken ? btb_target_q[rd_idx] : pc_q + W'(4);
    end

    assign wr_en  = is_control && is_taken;
    assign inv_en = is_control && is_br && !is_taken && (btb_tag_q[wr_idx] == wr_tag);

    always_comb begin
        btb_valid_d = btb_valid_q;
        if (wr_en) begin
            btb_valid_d[wr_idx] = 1'b1;
        end else if (inv_en) begin
            btb_valid_d[wr_idx] = 1'b0;
        end
    end

    always_comb begin
        state_d = StRun;
        pc_d    = pc_q;
        if (state_q == StRun) begin
            if (redirect) begin
                pc_d = redirect_pc;
            end else if (!stall) begin
                pc_d = pred_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StBoot;
            pc_q        <= RESET_VECTOR;
            btb_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag_q[wr_idx]    <= wr_tag;
            btb_target_q[wr_idx] <= branch_target;
            btb_cond_q[wr_idx]   <= is_br;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == StRun);

endmodule
